operand_dispatch: RTL and testbench

- Sequences register-file access for each decoded instruction: reads rs1/rs2 through the regfile, resolves busy operands against the ROB and the CDB, renames rd, and hands one operand-complete packet to the RS/LSB issue stage over a valid/ready handshake.
- Sits between the decoder and the regfile/issue stage. It is the only driver of the regfile read addresses and the reorder_* inputs.

---
 rtl/operand_dispatch_pkg.sv | 36 +++
 rtl/operand_dispatch_if.sv | 82 ++++++++
 rtl/operand_dispatch_resolve.sv | 35 +++
 rtl/operand_dispatch.sv | 127 ++++++++++++
 tb/tb_operand_dispatch.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_dispatch_pkg.sv
// Shared widths, packet types and the CDB wakeup helper for operand dispatch.
package operand_dispatch_pkg;

    localparam int unsigned RegIdBit    = 5;
    localparam int unsigned RobWidthBit = 4;
    localparam int unsigned WordBit     = 32;
    localparam int unsigned PayloadBit  = 64;

    typedef logic [RegIdBit-1:0]    reg_id_t;
    typedef logic [RobWidthBit-1:0] rob_id_t;
    typedef logic [WordBit-1:0]     word_t;
    typedef logic [PayloadBit-1:0]  payload_t;

    // One source operand: either a value, or a pending ROB tag when busy.
    typedef struct packed {
        word_t   value;
        rob_id_t tag;
        logic    busy;
    } operand_t;

    typedef enum logic [0:0] {StEmpty, StHeld} state_e;

    // Capture a CDB broadcast into a pending operand whose tag matches.
    function automatic operand_t wakeup(operand_t opnd, logic cdb_valid, rob_id_t cdb_tag,
                                        word_t cdb_value);
        operand_t res;
        res = opnd;
        if (opnd.busy && cdb_valid && (opnd.tag == cdb_tag)) begin
            res.value = cdb_value;
            res.tag   = '0;
            res.busy  = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/operand_dispatch_if.sv
// Decoder, regfile, ROB, CDB and issue-stage signals seen by operand dispatch.
interface operand_dispatch_if;
    import operand_dispatch_pkg::*;

    // Decoder side
    logic     dec_valid;
    logic     dec_ready;
    reg_id_t  dec_rs1;
    reg_id_t  dec_rs2;
    reg_id_t  dec_rd;
    logic     dec_use_rs1;
    logic     dec_use_rs2;
    logic     dec_wr_rd;
    rob_id_t  dec_rob_id;
    payload_t dec_payload;
    // Regfile read and rename
    reg_id_t  rf_rs1;
    reg_id_t  rf_rs2;
    logic     rf_rs1_busy;
    logic     rf_rs2_busy;
    word_t    rf_rs1_value;
    word_t    rf_rs2_value;
    rob_id_t  rf_rs1_re;
    rob_id_t  rf_rs2_re;
    logic     reorder_en;
    reg_id_t  reorder_reg;
    rob_id_t  reorder_id;
    // ROB ready query
    rob_id_t  rob_q1_id;
    rob_id_t  rob_q2_id;
    logic     rob_q1_ready;
    logic     rob_q2_ready;
    word_t    rob_q1_value;
    word_t    rob_q2_value;
    // Common data bus
    logic     cdb_valid;
    rob_id_t  cdb_rob_id;
    word_t    cdb_value;
    // Issue stage
    logic     iss_valid;
    logic     iss_ready;
    word_t    iss_vj;
    word_t    iss_vk;
    rob_id_t  iss_qj;
    rob_id_t  iss_qk;
    logic     iss_qj_busy;
    logic     iss_qk_busy;
    reg_id_t  iss_rd;
    rob_id_t  iss_rob_id;
    payload_t iss_payload;

    modport master (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2, dec_wr_rd,
        input  dec_rob_id, dec_payload,
        output dec_ready,
        output rf_rs1, rf_rs2,
        input  rf_rs1_busy, rf_rs2_busy, rf_rs1_value, rf_rs2_value, rf_rs1_re, rf_rs2_re,
        output reorder_en, reorder_reg, reorder_id,
        output rob_q1_id, rob_q2_id,
        input  rob_q1_ready, rob_q2_ready, rob_q1_value, rob_q2_value,
        input  cdb_valid, cdb_rob_id, cdb_value,
        output iss_valid, iss_vj, iss_vk, iss_qj, iss_qk, iss_qj_busy, iss_qk_busy,
        output iss_rd, iss_rob_id, iss_payload,
        input  iss_ready
    );

    modport slave (
        output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2, dec_wr_rd,
        output dec_rob_id, dec_payload,
        input  dec_ready,
        input  rf_rs1, rf_rs2,
        output rf_rs1_busy, rf_rs2_busy, rf_rs1_value, rf_rs2_value, rf_rs1_re, rf_rs2_re,
        input  reorder_en, reorder_reg, reorder_id,
        input  rob_q1_id, rob_q2_id,
        output rob_q1_ready, rob_q2_ready, rob_q1_value, rob_q2_value,
        output cdb_valid, cdb_rob_id, cdb_value,
        input  iss_valid, iss_vj, iss_vk, iss_qj, iss_qk, iss_qj_busy, iss_qk_busy,
        input  iss_rd, iss_rob_id, iss_payload,
        output iss_ready
    );

endinterface

// File: rtl/operand_dispatch_resolve.sv
// Combinational source-operand resolve: zero, regfile, ROB, CDB, else pending tag.
module operand_dispatch_resolve
    import operand_dispatch_pkg::*;
(
    input  logic     use_i,
    input  reg_id_t  rs_i,
    input  logic     rf_busy_i,
    input  word_t    rf_value_i,
    input  rob_id_t  rf_re_i,
    input  logic     rob_ready_i,
    input  word_t    rob_value_i,
    input  logic     cdb_valid_i,
    input  rob_id_t  cdb_rob_id_i,
    input  word_t    cdb_value_i,
    output operand_t opnd_o
);

    // Priority chain; unused operands and x0 read as constant zero.
    always_comb begin
        opnd_o = '0;
        if (use_i && (rs_i != '0)) begin
            if (!rf_busy_i) begin
                opnd_o.value = rf_value_i;
            end else if (rob_ready_i) begin
                opnd_o.value = rob_value_i;
            end else if (cdb_valid_i && (cdb_rob_id_i == rf_re_i)) begin
                opnd_o.value = cdb_value_i;
            end else begin
                opnd_o.tag  = rf_re_i;
                opnd_o.busy = 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_dispatch.sv
// Operand dispatch: reads and renames registers, holds one operand packet for issue.
module operand_dispatch
    import operand_dispatch_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                clear_all,
    operand_dispatch_if.master  bus
);

    state_e   st_q, st_d;
    operand_t opj_q, opj_d;
    operand_t opk_q, opk_d;
    reg_id_t  rd_q, rd_d;
    rob_id_t  rob_id_q, rob_id_d;
    payload_t payload_q, payload_d;

    operand_t res_j;
    operand_t res_k;
    logic     accept;

    // Regfile reads see the mapping before this instruction's own rename lands.
    assign bus.rf_rs1    = bus.dec_rs1;
    assign bus.rf_rs2    = bus.dec_rs2;
    assign bus.rob_q1_id = bus.rf_rs1_re;
    assign bus.rob_q2_id = bus.rf_rs2_re;

    assign bus.dec_ready   = rdy_in && !clear_all && ((st_q == StEmpty) || bus.iss_ready);
    assign accept          = bus.dec_valid && bus.dec_ready;
    assign bus.reorder_en  = accept && !rst_in && bus.dec_wr_rd && (bus.dec_rd != '0);
    assign bus.reorder_reg = bus.dec_rd;
    assign bus.reorder_id  = bus.dec_rob_id;

    operand_dispatch_resolve u_resolve_j (
        .use_i        (bus.dec_use_rs1),
        .rs_i         (bus.dec_rs1),
        .rf_busy_i    (bus.rf_rs1_busy),
        .rf_value_i   (bus.rf_rs1_value),
        .rf_re_i      (bus.rf_rs1_re),
        .rob_ready_i  (bus.rob_q1_ready),
        .rob_value_i  (bus.rob_q1_value),
        .cdb_valid_i  (bus.cdb_valid),
        .cdb_rob_id_i (bus.cdb_rob_id),
        .cdb_value_i  (bus.cdb_value),
        .opnd_o       (res_j)
    );

    operand_dispatch_resolve u_resolve_k (
        .use_i        (bus.dec_use_rs2),
        .rs_i         (bus.dec_rs2),
        .rf_busy_i    (bus.rf_rs2_busy),
        .rf_value_i   (bus.rf_rs2_value),
        .rf_re_i      (bus.rf_rs2_re),
        .rob_ready_i  (bus.rob_q2_ready),
        .rob_value_i  (bus.rob_q2_value),
        .cdb_valid_i  (bus.cdb_valid),
        .cdb_rob_id_i (bus.cdb_rob_id),
        .cdb_value_i  (bus.cdb_value),
        .opnd_o       (res_k)
    );

    // Next state: flush beats accept/issue/wakeup; a pause freezes everything.
    always_comb begin
        st_d      = st_q;
        opj_d     = opj_q;
        opk_d     = opk_q;
        rd_d      = rd_q;
        rob_id_d  = rob_id_q;
        payload_d = payload_q;
        if (clear_all) begin
            st_d      = StEmpty;
            opj_d     = '0;
            opk_d     = '0;
            rd_d      = '0;
            rob_id_d  = '0;
            payload_d = '0;
        end else if (rdy_in) begin
            if (accept) begin
                st_d      = StHeld;
                opj_d     = res_j;
                opk_d     = res_k;
                rd_d      = bus.dec_rd;
                rob_id_d  = bus.dec_rob_id;
                payload_d = bus.dec_payload;
            end else if (st_q == StHeld) begin
                if (bus.iss_ready) begin
                    st_d = StEmpty;
                end else begin
                    opj_d = wakeup(opj_q, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
                    opk_d = wakeup(opk_q, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
                end
            end
        end
    end

    // State and packet registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            st_q      <= StEmpty;
            opj_q     <= '0;
            opk_q     <= '0;
            rd_q      <= '0;
            rob_id_q  <= '0;
            payload_q <= '0;
        end else begin
            st_q      <= st_d;
            opj_q     <= opj_d;
            opk_q     <= opk_d;
            rd_q      <= rd_d;
            rob_id_q  <= rob_id_d;
            payload_q <= payload_d;
        end
    end

    assign bus.iss_valid   = (st_q == StHeld);
    assign bus.iss_vj      = opj_q.value;
    assign bus.iss_qj      = opj_q.tag;
    assign bus.iss_qj_busy = opj_q.busy;
    assign bus.iss_vk      = opk_q.value;
    assign bus.iss_qk      = opk_q.tag;
    assign bus.iss_qk_busy = opk_q.busy;
    assign bus.iss_rd      = rd_q;
    assign bus.iss_rob_id  = rob_id_q;
    assign bus.iss_payload = payload_q;

endmodule

// File: tb/tb_operand_dispatch.sv
// Bench for operand_dispatch: directed scenarios plus randomized traffic vs a reference model.
module tb_operand_dispatch;
    import operand_dispatch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clear;

    operand_dispatch_if ifc ();

    operand_dispatch dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .rdy_in    (rdy),
        .clear_all (clear),
        .bus       (ifc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] v;
        logic [3:0]  q;
        logic        b;
    } opnd_t;

    // Environment model: regfile with rename map, and ROB value store.
    logic        m_busy[32];
    logic [3:0]  m_tag[32];
    logic [31:0] m_val[32];
    logic        r_ready[16];
    logic [31:0] r_val[16];

    // Expected held packet.
    bit          e_valid;
    opnd_t       e_j, e_k;
    logic [4:0]  e_rd;
    logic [3:0]  e_rob;
    logic [63:0] e_pl;

    int checks = 0;
    int errors = 0;

    always_comb begin
        ifc.rf_rs1_busy  = m_busy[ifc.rf_rs1];
        ifc.rf_rs1_value = m_val[ifc.rf_rs1];
        ifc.rf_rs1_re    = m_tag[ifc.rf_rs1];
        ifc.rf_rs2_busy  = m_busy[ifc.rf_rs2];
        ifc.rf_rs2_value = m_val[ifc.rf_rs2];
        ifc.rf_rs2_re    = m_tag[ifc.rf_rs2];
        ifc.rob_q1_ready = r_ready[ifc.rob_q1_id];
        ifc.rob_q1_value = r_val[ifc.rob_q1_id];
        ifc.rob_q2_ready = r_ready[ifc.rob_q2_id];
        ifc.rob_q2_value = r_val[ifc.rob_q2_id];
    end

    function automatic opnd_t resolve(logic use_r, logic [4:0] r);
        opnd_t o;
        o = '0;
        if (!use_r || r == 5'd0) return o;
        if (!m_busy[r]) o.v = m_val[r];
        else if (r_ready[m_tag[r]]) o.v = r_val[m_tag[r]];
        else if (ifc.cdb_valid && ifc.cdb_rob_id == m_tag[r]) o.v = ifc.cdb_value;
        else begin
            o.q = m_tag[r];
            o.b = 1'b1;
        end
        return o;
    endfunction

    function automatic bit exp_ready();
        return rdy && !clear && (!e_valid || ifc.iss_ready);
    endfunction

    function automatic bit exp_ren();
        return !rst && ifc.dec_valid && exp_ready() && ifc.dec_wr_rd && ifc.dec_rd != 5'd0;
    endfunction

    // Advance one clock and apply the specified transfer rules to the model.
    task automatic tick();
        bit acc, wr, s_rst, s_clr, s_rdy, s_ir, c_v;
        opnd_t nj, nk;
        logic [4:0] rd;
        logic [3:0] rob, c_t;
        logic [31:0] c_d;
        logic [63:0] pl;
        acc = ifc.dec_valid && exp_ready();
        nj = resolve(ifc.dec_use_rs1, ifc.dec_rs1);
        nk = resolve(ifc.dec_use_rs2, ifc.dec_rs2);
        wr = ifc.dec_wr_rd; rd = ifc.dec_rd; rob = ifc.dec_rob_id; pl = ifc.dec_payload;
        s_rst = rst; s_clr = clear; s_rdy = rdy; s_ir = ifc.iss_ready;
        c_v = ifc.cdb_valid; c_t = ifc.cdb_rob_id; c_d = ifc.cdb_value;
        @(posedge clk);
        #1;
        if (s_rst || s_clr) begin
            e_valid = 0; e_j = '0; e_k = '0; e_rd = '0; e_rob = '0; e_pl = '0;
            if (s_clr) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else if (s_rdy) begin
            if (acc) begin
                e_valid = 1; e_j = nj; e_k = nk; e_rd = rd; e_rob = rob; e_pl = pl;
                if (wr && rd != 5'd0) begin
                    m_busy[rd] = 1'b1;
                    m_tag[rd]  = rob;
                end
            end else if (e_valid && s_ir) begin
                e_valid = 0;
            end else if (e_valid) begin
                if (e_j.b && c_v && c_t == e_j.q) begin e_j.v = c_d; e_j.q = 0; e_j.b = 0; end
                if (e_k.b && c_v && c_t == e_k.q) begin e_k.v = c_d; e_k.q = 0; e_k.b = 0; end
            end
        end
    endtask

    task automatic drive_dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input bit u1, input bit u2, input bit wr, input logic [3:0] rob,
                             input logic [63:0] pl);
        ifc.dec_valid = 1'b1; ifc.dec_rs1 = rs1; ifc.dec_rs2 = rs2; ifc.dec_rd = rd;
        ifc.dec_use_rs1 = u1; ifc.dec_use_rs2 = u2; ifc.dec_wr_rd = wr;
        ifc.dec_rob_id = rob; ifc.dec_payload = pl;
    endtask

    task automatic idle();
        ifc.dec_valid = 1'b0; ifc.dec_rs1 = '0; ifc.dec_rs2 = '0; ifc.dec_rd = '0;
        ifc.dec_use_rs1 = 1'b0; ifc.dec_use_rs2 = 1'b0; ifc.dec_wr_rd = 1'b0;
        ifc.dec_rob_id = '0; ifc.dec_payload = '0;
        ifc.cdb_valid = 1'b0; ifc.cdb_rob_id = '0; ifc.cdb_value = '0;
    endtask

    task automatic test_reset();
        checks++; if (ifc.iss_valid !== 1'b0) begin
            errors++; $display("FAIL rst_init_valid: got %b want 0", ifc.iss_valid); end
        m_val[1] = 32'h77;
        ifc.iss_ready = 1'b0;
        drive_dec(5'd1, 5'd0, 5'd2, 1, 0, 1, 4'd1, 64'hDEAD_BEEF);
        #1 tick();
        checks++; if (ifc.iss_vj !== 32'h77) begin
            errors++; $display("FAIL rst_pre_vj: got %h want 77", ifc.iss_vj); end
        rst = 1'b1;
        drive_dec(5'd1, 5'd0, 5'd3, 1, 0, 1, 4'd3, 64'h5);
        #1;
        checks++; if (ifc.reorder_en !== 1'b0) begin
            errors++; $display("FAIL rst_reorder_en: got %b want 0", ifc.reorder_en); end
        tick();
        rst = 1'b0; idle();
        #1;
        checks++; if (ifc.iss_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid: got %b want 0", ifc.iss_valid); end
        checks++; if ({ifc.iss_vj, ifc.iss_rd, ifc.iss_rob_id, ifc.iss_payload} !== '0) begin
            errors++; $display("FAIL rst_packet: got vj=%h rd=%h rob=%h pl=%h want 0",
                               ifc.iss_vj, ifc.iss_rd, ifc.iss_rob_id, ifc.iss_payload); end
        checks++; if (ifc.dec_ready !== 1'b1) begin
            errors++; $display("FAIL rst_dec_ready: got %b want 1", ifc.dec_ready); end
    endtask

    task automatic test_basic();
        m_busy[3] = 0; m_val[3] = 32'h11;
        m_busy[4] = 0; m_val[4] = 32'h22;
        ifc.iss_ready = 1'b0;
        drive_dec(5'd3, 5'd4, 5'd5, 1, 1, 1, 4'd2, 64'hA5A5_0000_1234_5678);
        #1;
        checks++; if ({ifc.reorder_en, ifc.reorder_reg, ifc.reorder_id} !== {1'b1, 5'd5, 4'd2})
        begin errors++; $display("FAIL basic_rename: got en=%b reg=%0d id=%0d want 1/5/2",
                                 ifc.reorder_en, ifc.reorder_reg, ifc.reorder_id); end
        checks++; if ({ifc.rf_rs1, ifc.rf_rs2} !== {5'd3, 5'd4}) begin
            errors++; $display("FAIL basic_rf_addr: got %0d/%0d want 3/4", ifc.rf_rs1, ifc.rf_rs2);
        end
        tick();
        idle();
        checks++; if (ifc.iss_valid !== 1'b1) begin
            errors++; $display("FAIL basic_valid: got %b want 1", ifc.iss_valid); end
        checks++; if ({ifc.iss_vj, ifc.iss_vk} !== {32'h11, 32'h22}) begin
            errors++; $display("FAIL basic_vals: got %h/%h want 11/22", ifc.iss_vj, ifc.iss_vk); end
        checks++; if ({ifc.iss_qj_busy, ifc.iss_qk_busy} !== 2'b00) begin
            errors++; $display("FAIL basic_busy: got %b%b want 00", ifc.iss_qj_busy,
                               ifc.iss_qk_busy); end
        checks++; if ({ifc.iss_rd, ifc.iss_rob_id, ifc.iss_payload} !==
                      {5'd5, 4'd2, 64'hA5A5_0000_1234_5678}) begin
            errors++; $display("FAIL basic_passthru: got rd=%0d rob=%0d pl=%h", ifc.iss_rd,
                               ifc.iss_rob_id, ifc.iss_payload); end
        #1;
        checks++; if (ifc.reorder_en !== 1'b0) begin
            errors++; $display("FAIL basic_ren_idle: got %b want 0", ifc.reorder_en); end
        ifc.iss_ready = 1'b1;
        tick();
        checks++; if (ifc.iss_valid !== 1'b0) begin
            errors++; $display("FAIL basic_drain: got %b want 0", ifc.iss_valid); end
    endtask

    task automatic test_cdb_wakeup();
        m_busy[7] = 1; m_tag[7] = 4'd6; r_ready[6] = 0;
        ifc.iss_ready = 1'b0;
        drive_dec(5'd7, 5'd4, 5'd8, 1, 0, 1, 4'd9, 64'hC0DE);
        #1;
        checks++; if (ifc.rob_q1_id !== 4'd6) begin
            errors++; $display("FAIL wake_q1_id: got %0d want 6", ifc.rob_q1_id); end
        tick();
        idle();
        checks++; if ({ifc.iss_qj_busy, ifc.iss_qj, ifc.iss_vj} !== {1'b1, 4'd6, 32'h0}) begin
            errors++; $display("FAIL wake_pending: got b=%b q=%0d v=%h want 1/6/0",
                               ifc.iss_qj_busy, ifc.iss_qj, ifc.iss_vj); end
        ifc.cdb_valid = 1'b1; ifc.cdb_rob_id = 4'd5; ifc.cdb_value = 32'hBEEF;
        tick();
        checks++; if (ifc.iss_qj_busy !== 1'b1) begin
            errors++; $display("FAIL wake_wrong_tag: got busy=%b want 1", ifc.iss_qj_busy); end
        ifc.cdb_rob_id = 4'd6; ifc.cdb_value = 32'hDEAD;
        tick();
        ifc.cdb_valid = 1'b0;
        checks++; if ({ifc.iss_qj_busy, ifc.iss_qj, ifc.iss_vj} !== {1'b0, 4'd0, 32'hDEAD}) begin
            errors++; $display("FAIL wake_capture: got b=%b q=%0d v=%h want 0/0/dead",
                               ifc.iss_qj_busy, ifc.iss_qj, ifc.iss_vj); end
        checks++; if ({ifc.iss_valid, ifc.iss_vk, ifc.iss_rd, ifc.iss_rob_id, ifc.iss_payload}
                      !== {1'b1, 32'h0, 5'd8, 4'd9, 64'hC0DE}) begin
            errors++; $display("FAIL wake_stable: got v=%b vk=%h rd=%0d rob=%0d pl=%h",
                               ifc.iss_valid, ifc.iss_vk, ifc.iss_rd, ifc.iss_rob_id,
                               ifc.iss_payload); end
        ifc.iss_ready = 1'b1;
        tick();
    endtask

    task automatic test_rob_forward();
        m_busy[7] = 1; m_tag[7] = 4'd6; r_ready[6] = 1; r_val[6] = 32'h55;
        ifc.iss_ready = 1'b0;
        drive_dec(5'd7, 5'd0, 5'd0, 1, 0, 1, 4'd10, 64'h1);
        #1;
        checks++; if (ifc.reorder_en !== 1'b0) begin
            errors++; $display("FAIL fwd_rd0_ren: got %b want 0", ifc.reorder_en); end
        tick();
        checks++; if ({ifc.iss_vj, ifc.iss_qj_busy} !== {32'h55, 1'b0}) begin
            errors++; $display("FAIL fwd_rob: got v=%h b=%b want 55/0", ifc.iss_vj,
                               ifc.iss_qj_busy); end
        m_busy[9] = 1; m_tag[9] = 4'd3; r_ready[3] = 0;
        ifc.iss_ready = 1'b1;
        drive_dec(5'd9, 5'd9, 5'd9, 1, 1, 1, 4'd11, 64'h2);
        #1;
        checks++; if ({ifc.dec_ready, ifc.reorder_en, ifc.reorder_reg, ifc.reorder_id} !==
                      {1'b1, 1'b1, 5'd9, 4'd11}) begin
            errors++; $display("FAIL fwd_rename: got rdy=%b en=%b reg=%0d id=%0d want 1/1/9/11",
                               ifc.dec_ready, ifc.reorder_en, ifc.reorder_reg, ifc.reorder_id);
        end
        tick();
        checks++; if ({ifc.iss_valid, ifc.iss_qj_busy, ifc.iss_qj, ifc.iss_qk, ifc.iss_rob_id}
                      !== {1'b1, 1'b1, 4'd3, 4'd3, 4'd11}) begin
            errors++; $display("FAIL fwd_old_producer: got v=%b b=%b qj=%0d qk=%0d rob=%0d",
                               ifc.iss_valid, ifc.iss_qj_busy, ifc.iss_qj, ifc.iss_qk,
                               ifc.iss_rob_id); end
        drive_dec(5'd9, 5'd0, 5'd1, 1, 0, 1, 4'd12, 64'h3);
        tick();
        idle();
        checks++; if ({ifc.iss_qj_busy, ifc.iss_qj} !== {1'b1, 4'd11}) begin
            errors++; $display("FAIL fwd_new_producer: got b=%b q=%0d want 1/11",
                               ifc.iss_qj_busy, ifc.iss_qj); end
        tick();
        checks++; if (ifc.iss_valid !== 1'b0) begin
            errors++; $display("FAIL fwd_drain: got %b want 0", ifc.iss_valid); end
    endtask

    task automatic test_back_to_back();
        int n_valid = 0;
        ifc.iss_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_dec(5'($urandom_range(31)), 5'($urandom_range(31)),
                      (i == 1) ? 5'd0 : 5'($urandom_range(31, 1)), 1'($urandom_range(1)),
                      1'($urandom_range(1)), 1, 4'($urandom_range(15)),
                      {$urandom, $urandom});
            #1;
            checks++; if (ifc.dec_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, ifc.dec_ready); end
            checks++; if (ifc.reorder_en !== exp_ren()) begin
                errors++; $display("FAIL b2b_ren[%0d]: got %b want %b", i, ifc.reorder_en,
                                   exp_ren()); end
            tick();
            if (ifc.iss_valid === 1'b1) n_valid++;
            checks++; if ({ifc.iss_vj, ifc.iss_qj, ifc.iss_qj_busy, ifc.iss_vk, ifc.iss_qk,
                           ifc.iss_qk_busy, ifc.iss_rd, ifc.iss_rob_id, ifc.iss_payload} !==
                          {e_j, e_k, e_rd, e_rob, e_pl}) begin
                errors++; $display("FAIL b2b_packet[%0d]: got %h want %h", i,
                                   {ifc.iss_vj, ifc.iss_qj, ifc.iss_qj_busy, ifc.iss_vk,
                                    ifc.iss_qk, ifc.iss_qk_busy, ifc.iss_rd, ifc.iss_rob_id,
                                    ifc.iss_payload}, {e_j, e_k, e_rd, e_rob, e_pl}); end
        end
        checks++; if (n_valid != 3) begin
            errors++; $display("FAIL b2b_no_bubble: got %0d valid cycles want 3", n_valid); end
        idle();
        tick();
        checks++; if (ifc.iss_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: got %b want 0", ifc.iss_valid); end
    endtask

    task automatic test_flush();
        ifc.iss_ready = 1'b0;
        drive_dec(5'd3, 5'd4, 5'd6, 1, 1, 1, 4'd5, 64'h77);
        tick();
        checks++; if (ifc.iss_valid !== 1'b1) begin
            errors++; $display("FAIL flush_pre: got %b want 1", ifc.iss_valid); end
        clear = 1'b1;
        drive_dec(5'd3, 5'd4, 5'd7, 1, 1, 1, 4'd6, 64'h88);
        #1;
        checks++; if ({ifc.dec_ready, ifc.reorder_en} !== 2'b00) begin
            errors++; $display("FAIL flush_handshake: got rdy=%b en=%b want 0/0",
                               ifc.dec_ready, ifc.reorder_en); end
        tick();
        clear = 1'b0;
        idle();
        #1;
        checks++; if ({ifc.iss_valid, ifc.iss_vj, ifc.dec_ready} !== {1'b0, 32'h0, 1'b1}) begin
            errors++; $display("FAIL flush_state: got v=%b vj=%h rdy=%b want 0/0/1",
                               ifc.iss_valid, ifc.iss_vj, ifc.dec_ready); end
        drive_dec(5'd3, 5'd0, 5'd0, 1, 0, 0, 4'd7, 64'h99);
        tick();
        idle();
        checks++; if ({ifc.iss_valid, ifc.iss_vj} !== {1'b1, 32'h11}) begin
            errors++; $display("FAIL flush_recover: got v=%b vj=%h want 1/11", ifc.iss_valid,
                               ifc.iss_vj); end
        ifc.iss_ready = 1'b1;
        tick();
    endtask

    task automatic test_pause();
        m_busy[10] = 1; m_tag[10] = 4'd13; r_ready[13] = 0;
        ifc.iss_ready = 1'b0;
        drive_dec(5'd10, 5'd0, 5'd4, 1, 0, 1, 4'd14, 64'hFACE);
        tick();
        rdy = 1'b0;
        ifc.iss_ready = 1'b1;
        drive_dec(5'd2, 5'd3, 5'd4, 1, 1, 1, 4'd15, 64'h9);
        ifc.cdb_valid = 1'b1; ifc.cdb_rob_id = 4'd13; ifc.cdb_value = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({ifc.dec_ready, ifc.reorder_en} !== 2'b00) begin
                errors++; $display("FAIL pause_handshake[%0d]: got rdy=%b en=%b want 0/0", i,
                                   ifc.dec_ready, ifc.reorder_en); end
            tick();
            checks++; if ({ifc.iss_valid, ifc.iss_qj_busy, ifc.iss_qj, ifc.iss_rob_id,
                           ifc.iss_payload} !== {1'b1, 1'b1, 4'd13, 4'd14, 64'hFACE}) begin
                errors++; $display("FAIL pause_hold[%0d]: got v=%b b=%b q=%0d rob=%0d pl=%h", i,
                                   ifc.iss_valid, ifc.iss_qj_busy, ifc.iss_qj, ifc.iss_rob_id,
                                   ifc.iss_payload); end
        end
        rdy = 1'b1;
        idle();
        tick();
        checks++; if (ifc.iss_valid !== 1'b0) begin
            errors++; $display("FAIL pause_resume: got %b want 0", ifc.iss_valid); end
    endtask

    task automatic test_random();
        int k;
        for (int n = 0; n < 400; n++) begin
            rdy   = ($urandom_range(9) != 0);
            clear = ($urandom_range(49) == 0);
            ifc.iss_ready = 1'($urandom_range(1));
            drive_dec(5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)),
                      1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                      4'($urandom_range(15)), {$urandom, $urandom});
            ifc.dec_valid = ($urandom_range(9) < 7);
            ifc.cdb_valid = ($urandom_range(9) < 4);
            ifc.cdb_rob_id = (e_valid && e_j.b && $urandom_range(1) == 1) ? e_j.q
                                                                          : 4'($urandom_range(15));
            ifc.cdb_value = $urandom;
            k = $urandom_range(31, 1);
            if ($urandom_range(2) == 0) begin m_busy[k] = 1'b0; m_val[k] = $urandom; end
            k = $urandom_range(15);
            r_ready[k] = 1'($urandom_range(1));
            r_val[k] = $urandom;
            #1;
            checks++; if (ifc.dec_ready !== exp_ready()) begin
                errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, ifc.dec_ready,
                                   exp_ready()); end
            checks++; if (ifc.reorder_en !== exp_ren() ||
                          (exp_ren() && {ifc.reorder_reg, ifc.reorder_id} !==
                                        {ifc.dec_rd, ifc.dec_rob_id})) begin
                errors++; $display("FAIL rnd_rename[%0d]: got en=%b reg=%0d id=%0d want en=%b",
                                   n, ifc.reorder_en, ifc.reorder_reg, ifc.reorder_id,
                                   exp_ren()); end
            tick();
            checks++; if (ifc.iss_valid !== e_valid) begin
                errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, ifc.iss_valid,
                                   e_valid); end
            if (e_valid) begin
                checks++; if ({ifc.iss_vj, ifc.iss_qj, ifc.iss_qj_busy, ifc.iss_vk, ifc.iss_qk,
                               ifc.iss_qk_busy, ifc.iss_rd, ifc.iss_rob_id, ifc.iss_payload}
                              !== {e_j, e_k, e_rd, e_rob, e_pl}) begin
                    errors++; $display("FAIL rnd_packet[%0d]: got %h want %h", n,
                                       {ifc.iss_vj, ifc.iss_qj, ifc.iss_qj_busy, ifc.iss_vk,
                                        ifc.iss_qk, ifc.iss_qk_busy, ifc.iss_rd,
                                        ifc.iss_rob_id, ifc.iss_payload},
                                       {e_j, e_k, e_rd, e_rob, e_pl}); end
            end
        end
        rdy = 1'b1; clear = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_busy[i] = 1'b0; m_tag[i] = '0; m_val[i] = 32'h100 + i;
        end
        for (int i = 0; i < 16; i++) begin
            r_ready[i] = 1'b0; r_val[i] = '0;
        end
        e_valid = 0; e_j = '0; e_k = '0; e_rd = '0; e_rob = '0; e_pl = '0;
        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        ifc.iss_ready = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_cdb_wakeup();
        test_rob_forward();
        test_back_to_back();
        test_flush();
        test_pause();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
